sweep_acq_uplink: RTL and testbench
===================================

SWEEP_ACQ_UPLINK -- requirements
Module: sweep_acq_uplink

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, 256, payload buffer depth in 16-bit words (power of 2).
REQ-002 SHALL have parameter HEADER_WORD, 16'hFF45, first word of every step frame.
REQ-003 SHALL have parameter TRAILER_WORD, 16'hFF54, last word of every step frame.
REQ-004 SHALL have port Clk  in  1  system clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port SweepACQData  in  16  sweep acquisition word from upstream.
REQ-007 SHALL have port SweepACQData_en  in  1  one-cycle qualifier per SweepACQData word.
REQ-008 SHALL have port StepDone  in  1  one-cycle pulse: upstream has delivered its last word for the current DAC point.
REQ-009 SHALL have port CurrentDAC  in  10  DAC0 value of the step; sampled with StepDone.
REQ-010 SHALL have port UsbData  out  16  word to USB slave FIFO.
REQ-011 SHALL have port UsbData_en  out  1  write strobe, one cycle per word.
REQ-012 SHALL have port UsbFull  in  1  USB FIFO full; no write may issue while high.
REQ-013 SHALL have port DataTransmitDone  out  1  one-cycle pulse, step frame fully written.
REQ-014 SHALL have port Overflow  out  1  sticky error flag.
REQ-015 SHALL have port Busy  out  1  high whenever FSM is not IDLE.

Function
REQ-016 SHALL write SweepACQData into an internal FIFO_DEPTH-word FIFO on every cycle SweepACQData_en is high and the FIFO is not full.
REQ-017 SHALL drop the word and set Overflow when SweepACQData_en is high with the FIFO full; dropped words are not counted.
REQ-018 SHALL keep a 16-bit accumulating counter of accepted words since the last StepDone, including a word accepted in the same cycle as StepDone.
REQ-019 SHALL, on StepDone, latch the accumulated count into SendCount, latch CurrentDAC, set a one-deep Pending flag and clear the accumulator (a same-cycle word counts as 1 toward the old step; the accumulator restarts at 0).
REQ-020 SHALL set Overflow if StepDone arrives while Pending is already set; the new StepDone is then ignored.
REQ-021 SHALL implement FSM states IDLE, HEADER, DAC, PAYLOAD, TRAILER, DONE.
REQ-022 SHALL go IDLE->HEADER on the cycle after Pending is set, clearing Pending on that transition.
REQ-023 SHALL emit HEADER_WORD, then {6'b0, latched DAC}, then exactly SendCount FIFO words in order, then TRAILER_WORD; each state advances only after its word is written.
REQ-024 SHALL register UsbData/UsbData_en so a word appears on the edge following a cycle in which UsbFull was low; UsbFull high stalls in place with UsbData_en low and no data lost.
REQ-025 SHALL sustain one word per cycle while UsbFull stays low, including back-to-back FIFO pops in PAYLOAD.
REQ-026 SHALL skip PAYLOAD when SendCount is 0 (frame = header, DAC, trailer).
REQ-027 SHALL pulse DataTransmitDone in DONE for exactly one cycle, then return to IDLE, re-entering HEADER next cycle if Pending is set.
REQ-028 SHALL allow simultaneous FIFO write and read in the same cycle.
REQ-029 SHALL keep Overflow set until reset.
REQ-030 SHALL yield DataTransmitDone k+5 cycles after StepDone for k payload words with UsbFull low throughout (header at +2).

Reset
REQ-031 SHALL, on reset_n low, asynchronously clear UsbData to 0, and UsbData_en, DataTransmitDone, Overflow, Busy, Pending, counters and FIFO pointers to 0, FSM to IDLE.
REQ-032 SHALL, on reset mid-frame, abandon the frame with no DataTransmitDone, and resume normally after release.

Verification
REQ-033 SHALL verify: 3 words 16'h0001..0003, StepDone with CurrentDAC=10'h155, UsbFull low -> FF45, 0155, 0001, 0002, 0003, FF54 on consecutive cycles; DataTransmitDone at StepDone+8.
REQ-034 SHALL verify: StepDone with no data -> FF45, DAC word, FF54; one DataTransmitDone.
REQ-035 SHALL verify: UsbFull high 4 cycles in mid-payload -> UsbData_en low for those cycles; word sequence unchanged and complete.
REQ-036 SHALL verify: 260 words without StepDone (depth 256) -> Overflow=1, frame carries count 256 and the first 256 words.
REQ-037 SHALL verify: step-2 data plus second StepDone during step-1 transmission -> two frames back-to-back, correct counts, two DataTransmitDone pulses.
REQ-038 SHALL verify: reset_n low during PAYLOAD -> outputs 0 immediately; a subsequent 1-word step frames correctly.

Source files
------------

// File: rtl/sweep_acq_uplink.sv
// Sweep acquisition uplink: buffers upstream acquisition words in a FIFO and,
// once per completed DAC step, sends a framed packet to a USB slave FIFO:
//   HEADER_WORD, {6'b0, DAC}, <SendCount payload words>, TRAILER_WORD
//
// Handshake: the downstream side uses a ready-low "full" flag. A word is
// written (UsbData_en high for one cycle) only if UsbFull was low in the
// preceding cycle; while UsbFull is high the FSM holds its state and no word
// is consumed. Upstream words carry a one-cycle valid (SweepACQData_en) with
// no backpressure; words arriving while the FIFO is full are dropped and flag
// Overflow.
module sweep_acq_uplink #(
  parameter int          FIFO_DEPTH   = 256,
  parameter logic [15:0] HEADER_WORD  = 16'hFF45,
  parameter logic [15:0] TRAILER_WORD = 16'hFF54
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic [15:0] SweepACQData,
  input  logic        SweepACQData_en,
  input  logic        StepDone,
  input  logic [9:0]  CurrentDAC,
  output logic [15:0] UsbData,
  output logic        UsbData_en,
  input  logic        UsbFull,
  output logic        DataTransmitDone,
  output logic        Overflow,
  output logic        Busy,
  output logic [2:0]  dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HEADER  = 3'd1;
  localparam logic [2:0] S_DAC     = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_TRAILER = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  // FIFO storage and pointers (pointers carry one extra wrap bit)
  logic [15:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] fifo_fill;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_wr;
  logic        fifo_rd;
  logic [15:0] fifo_rdata;

  // Step bookkeeping
  logic [15:0] acc_q, acc_d;
  logic [15:0] send_count_q, send_count_d;
  logic [9:0]  dac_q, dac_d;
  logic        pending_q, pending_d;
  logic        step_accept;

  // Frame in flight (copied from the step latches when the frame starts, so a
  // new StepDone can be latched while this frame is still going out)
  logic [15:0] remain_q, remain_d;
  logic [9:0]  frame_dac_q, frame_dac_d;
  logic [2:0]  state_q, state_d;

  // Registered outputs
  logic [15:0] usb_data_q, usb_data_d;
  logic        usb_en_q, usb_en_d;
  logic        done_q, done_d;
  logic        overflow_q, overflow_d;

  assign fifo_fill   = wr_ptr_q - rd_ptr_q;
  assign fifo_full   = (fifo_fill == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty  = (fifo_fill == '0);
  assign fifo_wr     = SweepACQData_en && !fifo_full;
  assign fifo_rdata  = fifo_mem[rd_ptr_q[AW-1:0]];
  // A second StepDone while one is still waiting to start is ignored
  assign step_accept = StepDone && !pending_q;

  // FIFO pointer next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, fifo_wr};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, fifo_rd};
  end

  // Step accounting, frame sequencing and output word selection
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    acc_d        = acc_q + {15'b0, fifo_wr};
    send_count_d = send_count_q;
    dac_d        = dac_q;
    remain_d     = remain_q;
    frame_dac_d  = frame_dac_q;
    usb_data_d   = usb_data_q;
    usb_en_d     = 1'b0;
    done_d       = 1'b0;
    fifo_rd      = 1'b0;
    overflow_d   = overflow_q | (SweepACQData_en & fifo_full) | (StepDone & pending_q);

    // A word accepted alongside StepDone belongs to the step that is closing
    if (step_accept) begin
      send_count_d = acc_q + {15'b0, fifo_wr};
      dac_d        = CurrentDAC;
      pending_d    = 1'b1;
      acc_d        = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          state_d     = S_HEADER;
          pending_d   = 1'b0;
          remain_d    = send_count_q;
          frame_dac_d = dac_q;
        end
      end
      S_HEADER: begin
        if (!UsbFull) begin
          usb_data_d = HEADER_WORD;
          usb_en_d   = 1'b1;
          state_d    = S_DAC;
        end
      end
      S_DAC: begin
        if (!UsbFull) begin
          usb_data_d = {6'b0, frame_dac_q};
          usb_en_d   = 1'b1;
          state_d    = (remain_q == 16'd0) ? S_TRAILER : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        // The empty guard only matters if counts and FIFO ever disagree
        if (!UsbFull && !fifo_empty) begin
          usb_data_d = fifo_rdata;
          usb_en_d   = 1'b1;
          fifo_rd    = 1'b1;
          remain_d   = remain_q - 16'd1;
          if (remain_q == 16'd1) state_d = S_TRAILER;
        end
      end
      S_TRAILER: begin
        if (!UsbFull) begin
          usb_data_d = TRAILER_WORD;
          usb_en_d   = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO storage write (data array needs no reset)
  always_ff @(posedge Clk) begin
    if (fifo_wr) fifo_mem[wr_ptr_q[AW-1:0]] <= SweepACQData;
  end

  // Control and output registers with asynchronous active-low reset
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      acc_q        <= '0;
      send_count_q <= '0;
      dac_q        <= '0;
      pending_q    <= 1'b0;
      remain_q     <= '0;
      frame_dac_q  <= '0;
      state_q      <= S_IDLE;
      usb_data_q   <= '0;
      usb_en_q     <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      acc_q        <= acc_d;
      send_count_q <= send_count_d;
      dac_q        <= dac_d;
      pending_q    <= pending_d;
      remain_q     <= remain_d;
      frame_dac_q  <= frame_dac_d;
      state_q      <= state_d;
      usb_data_q   <= usb_data_d;
      usb_en_q     <= usb_en_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign UsbData          = usb_data_q;
  assign UsbData_en       = usb_en_q;
  assign DataTransmitDone = done_q;
  assign Overflow         = overflow_q;
  assign Busy             = (state_q != S_IDLE);
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_sweep_acq_uplink.sv
// Directed testbench for sweep_acq_uplink: drives acquisition words and step
// pulses, captures every USB write with its cycle number and compares frames
// against hand-built expected word lists.
module tb_sweep_acq_uplink;

  logic        Clk;
  logic        reset_n;
  logic [15:0] SweepACQData;
  logic        SweepACQData_en;
  logic        StepDone;
  logic [9:0]  CurrentDAC;
  logic [15:0] UsbData;
  logic        UsbData_en;
  logic        UsbFull;
  logic        DataTransmitDone;
  logic        Overflow;
  logic        Busy;
  logic [2:0]  dbg_state;

  sweep_acq_uplink dut (
    .Clk              (Clk),
    .reset_n          (reset_n),
    .SweepACQData     (SweepACQData),
    .SweepACQData_en  (SweepACQData_en),
    .StepDone         (StepDone),
    .CurrentDAC       (CurrentDAC),
    .UsbData          (UsbData),
    .UsbData_en       (UsbData_en),
    .UsbFull          (UsbFull),
    .DataTransmitDone (DataTransmitDone),
    .Overflow         (Overflow),
    .Busy             (Busy),
    .dbg_state        (dbg_state)
  );

  // Clock and cycle counter
  int cyc = 0;
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end
  always @(posedge Clk) cyc++;

  // Scoreboard state
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          gcyc_q[$];
  int          done_cnt = 0;
  int          n_checks = 0;
  int          n_pass   = 0;

  // Monitor: sample outputs on the falling edge
  always @(negedge Clk) begin
    if (UsbData_en) begin
      got_q.push_back(UsbData);
      gcyc_q.push_back(cyc);
    end
    if (DataTransmitDone) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_frame(input string tag);
    int n;
    check({tag, " len"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s word%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    gcyc_q.delete();
    exp_q.delete();
  endtask

  // Driver tasks: all inputs change on the falling edge
  task automatic drive_cycle(input logic en, input logic [15:0] data, input logic sd,
                             input logic [9:0] dac);
    @(negedge Clk);
    SweepACQData_en = en;
    SweepACQData    = data;
    StepDone        = sd;
    CurrentDAC      = dac;
  endtask

  task automatic send_word(input logic [15:0] w);
    drive_cycle(1'b1, w, 1'b0, 10'd0);
  endtask

  // Returns the cycle number of the edge that samples StepDone
  task automatic step_done(input logic [9:0] dac, output int sd_cyc);
    drive_cycle(1'b0, 16'd0, 1'b1, dac);
    sd_cyc = cyc + 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 16'd0, 1'b0, 10'd0);
  endtask

  task automatic wait_done(input int budget, output logic seen, output int at_cyc);
    seen   = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (DataTransmitDone) begin
        seen   = 1'b1;
        at_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic push_frame_head(input logic [9:0] dac);
    exp_q.push_back(16'hFF45);
    exp_q.push_back({6'b0, dac});
  endtask

  initial begin
    int   sd, sd2, at, win, d0;
    logic seen;

    reset_n         = 1'b1;
    SweepACQData    = '0;
    SweepACQData_en = 1'b0;
    StepDone        = 1'b0;
    CurrentDAC      = '0;
    UsbFull         = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    check("rst UsbData", UsbData, 16'h0000);
    check("rst UsbData_en", UsbData_en, 1'b0);
    check("rst Done", DataTransmitDone, 1'b0);
    check("rst Overflow", Overflow, 1'b0);
    check("rst Busy", Busy, 1'b0);
    @(negedge Clk);
    reset_n = 1'b1;
    idle(2);

    // 1: three words, DAC 155, no stalls
    send_word(16'h0001);
    send_word(16'h0002);
    send_word(16'h0003);
    step_done(10'h155, sd);
    idle(1);
    d0 = done_cnt;
    wait_done(50, seen, at);
    check("t1 done seen", seen, 1'b1);
    check("t1 done cycle", at, sd + 8);
    check("t1 header cycle", (gcyc_q.size() > 0) ? gcyc_q[0] : -1, sd + 2);
    check("t1 trailer cycle", (gcyc_q.size() == 6) ? gcyc_q[5] : -1, sd + 7);
    idle(2);
    check("t1 done pulses", done_cnt - d0, 1);
    check("t1 idle Busy", Busy, 1'b0);
    push_frame_head(10'h155);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0003);
    exp_q.push_back(16'hFF54);
    check_frame("t1");

    // 2: empty step
    step_done(10'h02A, sd);
    idle(1);
    d0 = done_cnt;
    wait_done(50, seen, at);
    check("t2 done cycle", at, sd + 5);
    idle(3);
    check("t2 done pulses", done_cnt - d0, 1);
    push_frame_head(10'h02A);
    exp_q.push_back(16'hFF54);
    check_frame("t2");

    // 3: UsbFull held high for 4 cycles during payload
    for (int i = 0; i < 6; i++) send_word(16'h0010 + 16'(i));
    step_done(10'h003, sd);
    idle(1);
    while (cyc < sd + 5) @(negedge Clk);
    UsbFull = 1'b1;
    repeat (4) @(negedge Clk);
    UsbFull = 1'b0;
    wait_done(50, seen, at);
    check("t3 done cycle", at, sd + 15);
    win = 0;
    foreach (gcyc_q[i]) if (gcyc_q[i] >= sd + 6 && gcyc_q[i] <= sd + 9) win++;
    check("t3 writes while full", win, 0);
    push_frame_head(10'h003);
    for (int i = 0; i < 6; i++) exp_q.push_back(16'h0010 + 16'(i));
    exp_q.push_back(16'hFF54);
    idle(2);
    check_frame("t3");

    // 4: 260 words into a 256-word FIFO
    for (int i = 0; i < 256; i++) send_word(16'h0100 + 16'(i));
    idle(1);
    check("t4 no overflow at 256", Overflow, 1'b0);
    for (int i = 0; i < 4; i++) send_word(16'h0900 + 16'(i));
    step_done(10'h3FF, sd);
    idle(1);
    check("t4 overflow", Overflow, 1'b1);
    wait_done(400, seen, at);
    check("t4 done cycle", at, sd + 261);
    push_frame_head(10'h3FF);
    for (int i = 0; i < 256; i++) exp_q.push_back(16'h0100 + 16'(i));
    exp_q.push_back(16'hFF54);
    idle(2);
    check_frame("t4");
    check("t4 overflow sticky", Overflow, 1'b1);

    // 5: step-2 data and StepDone arrive while step 1 is being sent
    for (int i = 0; i < 4; i++) send_word(16'h00A0 + 16'(i));
    step_done(10'h001, sd);
    send_word(16'h00B0);
    send_word(16'h00B1);
    step_done(10'h002, sd2);
    idle(1);
    d0 = done_cnt;
    wait_done(50, seen, at);
    check("t5 done1 cycle", at, sd + 9);
    wait_done(50, seen, at);
    check("t5 done2 seen", seen, 1'b1);
    idle(2);
    check("t5 done pulses", done_cnt - d0, 2);
    push_frame_head(10'h001);
    for (int i = 0; i < 4; i++) exp_q.push_back(16'h00A0 + 16'(i));
    exp_q.push_back(16'hFF54);
    push_frame_head(10'h002);
    exp_q.push_back(16'h00B0);
    exp_q.push_back(16'h00B1);
    exp_q.push_back(16'hFF54);
    check_frame("t5");

    // 6: reset during payload, then a one-word step
    for (int i = 0; i < 5; i++) send_word(16'h0C00 + 16'(i));
    step_done(10'h0C5, sd);
    idle(1);
    while (cyc < sd + 5) @(negedge Clk);
    check("t6 busy before reset", Busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("t6 rst UsbData", UsbData, 16'h0000);
    check("t6 rst UsbData_en", UsbData_en, 1'b0);
    check("t6 rst Busy", Busy, 1'b0);
    check("t6 rst Overflow", Overflow, 1'b0);
    repeat (2) @(negedge Clk);
    reset_n = 1'b1;
    got_q.delete();
    gcyc_q.delete();
    d0 = done_cnt;
    idle(20);
    check("t6 no done after abort", done_cnt - d0, 0);
    check("t6 no writes after abort", got_q.size(), 0);
    send_word(16'h0077);
    step_done(10'h0AB, sd);
    idle(1);
    wait_done(50, seen, at);
    check("t6 done cycle", at, sd + 6);
    push_frame_head(10'h0AB);
    exp_q.push_back(16'h0077);
    exp_q.push_back(16'hFF54);
    idle(2);
    check_frame("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
